// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel programmable clock/tick divider with boundary-synchronous reconfiguration
module clk_div_prog #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 50000000,
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    input  logic                cfg_en,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] DEF_D = (DEFAULT_DIV == 0) ? WIDTH'(1) : WIDTH'(DEFAULT_DIV);

    logic [CHANNELS-1:0] pnd_vec;
    logic [WIDTH-1:0]    cfg_div_fix;

    assign cfg_div_fix = (cfg_div == '0) ? WIDTH'(1) : cfg_div;

    // Channel numbers with no matching channel fall through with ready held high.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pnd_vec[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] div_act;
        logic [WIDTH-1:0] div_pnd;
        logic             mode_act;
        logic             mode_pnd;
        logic             en_act;
        logic             pnd;
        logic             out_r;
        logic             tick_r;
        logic             hit;
        logic             boundary;

        assign hit      = cfg_valid && (cfg_ch == CH_W'(g)) && !pnd;
        assign boundary = en_act && (count == div_act - WIDTH'(1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count    <= '0;
                div_act  <= DEF_D;
                div_pnd  <= '0;
                mode_act <= 1'b0;
                mode_pnd <= 1'b0;
                en_act   <= 1'b1;
                pnd      <= 1'b0;
                out_r    <= 1'b0;
                tick_r   <= 1'b0;
            end else if (hit && !en_act) begin
                div_act  <= cfg_div_fix;
                mode_act <= cfg_mode;
                en_act   <= cfg_en;
                count    <= '0;
                out_r    <= 1'b0;
                tick_r   <= 1'b0;
                pnd      <= 1'b0;
            end else if (hit && !cfg_en) begin
                en_act   <= 1'b0;
                count    <= '0;
                out_r    <= 1'b0;
                tick_r   <= 1'b0;
                pnd      <= 1'b0;
            end else begin
                // A capture here never coincides with an apply: hit requires pnd clear.
                if (hit) begin
                    pnd      <= 1'b1;
                    div_pnd  <= cfg_div_fix;
                    mode_pnd <= cfg_mode;
                end
                if (!en_act) begin
                    count  <= '0;
                    out_r  <= 1'b0;
                    tick_r <= 1'b0;
                end else if (boundary) begin
                    count  <= '0;
                    tick_r <= 1'b1;
                    if (pnd) begin
                        out_r    <= 1'b0;
                        div_act  <= div_pnd;
                        mode_act <= mode_pnd;
                        pnd      <= 1'b0;
                    end else if (mode_act) begin
                        out_r <= 1'b1;
                    end else begin
                        out_r <= ~out_r;
                    end
                end else begin
                    count  <= count + WIDTH'(1);
                    tick_r <= 1'b0;
                    if (mode_act) begin
                        out_r <= 1'b0;
                    end
                end
            end
        end

        assign pnd_vec[g] = pnd;
        assign out[g]     = out_r;
        assign tick[g]    = tick_r;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed vector bench for clk_div_prog (3 channels, 8-bit, default divisor 4)
module tb_clk_div_prog;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_mode;
    logic       cfg_en;
    logic [2:0] out;
    logic [2:0] tick;

    clk_div_prog #(
        .CHANNELS    (3),
        .WIDTH       (8),
        .DEFAULT_DIV (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_en    (cfg_en),
        .out       (out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] ch;
        logic [7:0] div;
        logic       mode;
        logic       en;
        logic       ready;
        logic [2:0] exp_out;
        logic [2:0] exp_tick;
    } vec_t;

    vec_t vecs[49];
    int   nvec;
    int   errors;
    int   checks;

    task automatic v(input logic valid, input logic [1:0] ch, input logic [7:0] div,
                     input logic mode, input logic en, input logic ready,
                     input logic [2:0] eo, input logic [2:0] et);
        vecs[nvec] = '{valid, ch, div, mode, en, ready, eo, et};
        nvec++;
    endtask

    task automatic chk(input string name, input int idx, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got %b want %b", name, idx, got, want);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        nvec      = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd0;
        cfg_mode  = 1'b0;
        cfg_en    = 1'b0;

        // Rows are indexed by the edge after reset release that they lead into; out/tick = {ch2,ch1,ch0}.
        for (int k = 1; k <= 12; k++) begin
            case (k % 4)
                0:       v(0, 0, 0, 0, 0, 1, (k % 8 == 0) ? 3'b000 : 3'b111, 3'b111);
                default: v(0, 0, 0, 0, 0, 1, ((k / 4) % 2 == 1) ? 3'b111 : 3'b000, 3'b000);
            endcase
        end
        v(1, 1, 3, 1, 1, 1, 3'b111, 3'b000);   // 13: ch1 -> D=3 pulse, captured
        v(0, 1, 0, 0, 0, 0, 3'b111, 3'b000);   // 14
        v(0, 1, 0, 0, 0, 0, 3'b111, 3'b000);   // 15
        v(0, 1, 0, 0, 0, 0, 3'b000, 3'b111);   // 16: ch1 applies with out low
        v(0, 1, 0, 0, 0, 1, 3'b000, 3'b000);   // 17
        v(0, 1, 0, 0, 0, 1, 3'b000, 3'b000);   // 18
        v(0, 1, 0, 0, 0, 1, 3'b010, 3'b010);   // 19
        v(0, 1, 0, 0, 0, 1, 3'b101, 3'b101);   // 20
        v(0, 1, 0, 0, 0, 1, 3'b101, 3'b000);   // 21
        v(0, 1, 0, 0, 0, 1, 3'b111, 3'b010);   // 22
        v(0, 1, 0, 0, 0, 1, 3'b101, 3'b000);   // 23
        v(0, 1, 0, 0, 0, 1, 3'b000, 3'b101);   // 24
        v(0, 1, 0, 0, 0, 1, 3'b010, 3'b010);   // 25
        v(0, 0, 0, 0, 0, 1, 3'b000, 3'b000);   // 26
        v(0, 0, 0, 0, 0, 1, 3'b000, 3'b000);   // 27
        v(1, 0, 2, 0, 1, 1, 3'b111, 3'b111);   // 28: ch0 D=2 written on its boundary cycle
        v(1, 0, 5, 0, 1, 0, 3'b101, 3'b000);   // 29: second write refused
        v(0, 0, 0, 0, 0, 0, 3'b101, 3'b000);   // 30
        v(0, 0, 0, 0, 0, 0, 3'b111, 3'b010);   // 31
        v(0, 0, 0, 0, 0, 0, 3'b000, 3'b101);   // 32: old period ran once more, apply
        v(0, 0, 0, 0, 0, 1, 3'b000, 3'b000);   // 33
        v(0, 0, 0, 0, 0, 1, 3'b011, 3'b011);   // 34: period 2
        v(0, 0, 0, 0, 0, 1, 3'b001, 3'b000);   // 35
        v(1, 0, 9, 0, 0, 1, 3'b100, 3'b100);   // 36: stop ch0 while high
        v(0, 0, 0, 0, 0, 1, 3'b110, 3'b010);   // 37
        v(0, 0, 0, 0, 0, 1, 3'b100, 3'b000);   // 38
        v(1, 0, 1, 0, 1, 1, 3'b100, 3'b000);   // 39: restart ch0 D=1 toggle
        v(0, 0, 0, 0, 0, 1, 3'b011, 3'b111);   // 40
        v(0, 0, 0, 0, 0, 1, 3'b000, 3'b001);   // 41
        v(0, 0, 0, 0, 0, 1, 3'b001, 3'b001);   // 42
        v(1, 0, 0, 1, 1, 1, 3'b010, 3'b011);   // 43: ch0 D=0 pulse, pending
        v(0, 0, 0, 0, 0, 0, 3'b100, 3'b101);   // 44
        v(0, 0, 0, 0, 0, 1, 3'b101, 3'b001);   // 45
        v(1, 3, 7, 0, 0, 1, 3'b111, 3'b011);   // 46: write to absent channel 3
        v(0, 0, 0, 0, 0, 1, 3'b101, 3'b001);   // 47
        v(0, 0, 0, 0, 0, 1, 3'b001, 3'b101);   // 48
        v(0, 0, 0, 0, 0, 1, 3'b011, 3'b011);   // 49

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 0, out, 3'b000);
        chk("reset_tick", 0, tick, 3'b000);
        for (int c = 0; c < 3; c++) begin
            cfg_ch = 2'(c);
            #1;
            chk("reset_ready", c, {2'b00, cfg_ready}, 3'b001);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < nvec; r++) begin
            cfg_valid = vecs[r].valid;
            cfg_ch    = vecs[r].ch;
            cfg_div   = vecs[r].div;
            cfg_mode  = vecs[r].mode;
            cfg_en    = vecs[r].en;
            #1;
            chk("ready", r + 1, {2'b00, cfg_ready}, {2'b00, vecs[r].ready});
            @(posedge clk);
            #1;
            chk("out", r + 1, out, vecs[r].exp_out);
            chk("tick", r + 1, tick, vecs[r].exp_tick);
        end

        // Asynchronous reset with ch1 holding a pending update.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 8'd2;
        cfg_mode  = 1'b1;
        cfg_en    = 1'b1;
        #1;
        chk("ar_ready_pre", 0, {2'b00, cfg_ready}, 3'b001);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        #1;
        chk("ar_ready_pnd", 0, {2'b00, cfg_ready}, 3'b000);
        chk("ar_out_pre", 0, out, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out", 0, out, 3'b000);
        chk("ar_tick", 0, tick, 3'b000);
        chk("ar_ready", 0, {2'b00, cfg_ready}, 3'b001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("ar_run_out", k + 1, out, vecs[k].exp_out);
            chk("ar_run_tick", k + 1, tick, vecs[k].exp_tick);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
